mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_if.sv | 36 +++
 rtl/mem_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Request/response bundle between the fetch port, the mem-stage port and the single-port RAM.
// master is the arbiter's view; slave is the requester/RAM side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic [DATA_W-1:0]     if_rdata;
  logic                  if_ack;
  logic                  if_stall;
  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  mem_ack;
  logic                  mem_stall;
  logic                  ram_ce;
  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W/8-1:0]   ram_we;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;

  modport master (
    input  if_req, if_addr, mem_req, mem_addr, mem_we, mem_wdata, ram_rdata,
    output if_rdata, if_ack, if_stall, mem_rdata, mem_ack, mem_stall,
           ram_ce, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    output if_req, if_addr, mem_req, mem_addr, mem_we, mem_wdata, ram_rdata,
    input  if_rdata, if_ack, if_stall, mem_rdata, mem_ack, mem_stall,
           ram_ce, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch and mem-stage requests onto one single-port RAM (IDLE -> ACCESS -> RESP).
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is mem-port priority.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.master bus
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  logic                owner_mem;
  logic [DATA_W-1:0]   if_rdata_hold;
  logic [DATA_W-1:0]   mem_rdata_hold;
  logic                cand_if;
  logic                cand_mem;
  logic                grant_valid;
  logic                grant_mem;
  logic                resp_read;
`ifdef MEM_ARB_RR_EN
  logic                last_mem;
`endif

  // Grant decision; the port being acked in RESP may not win again immediately.
  always_comb begin
    cand_if  = bus.if_req;
    cand_mem = bus.mem_req;
    if (state == RESP) begin
      if (owner_mem) begin
        cand_mem = 1'b0;
      end else begin
        cand_if = 1'b0;
      end
    end else begin
      cand_if  = bus.if_req;
      cand_mem = bus.mem_req;
    end
    grant_valid = ((state == IDLE) || (state == RESP)) && (cand_if || cand_mem);
`ifdef MEM_ARB_RR_EN
    if (cand_if && cand_mem) begin
      grant_mem = ~last_mem;
    end else begin
      grant_mem = cand_mem;
    end
`else
    grant_mem = cand_mem;
`endif
  end

  // RAM read data is only valid in RESP, so it is steered straight out alongside the ack.
  assign resp_read     = (state == RESP) && (bus.ram_we == {BE_W{1'b0}});
  assign bus.if_rdata  = (resp_read && !owner_mem) ? bus.ram_rdata : if_rdata_hold;
  assign bus.mem_rdata = (resp_read &&  owner_mem) ? bus.ram_rdata : mem_rdata_hold;
  assign bus.if_stall  = bus.if_req  & ~bus.if_ack;
  assign bus.mem_stall = bus.mem_req & ~bus.mem_ack;

  // Arbiter FSM with registered RAM command and acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      owner_mem      <= 1'b0;
      bus.ram_ce     <= 1'b0;
      bus.ram_addr   <= {ADDR_W{1'b0}};
      bus.ram_we     <= {BE_W{1'b0}};
      bus.ram_wdata  <= {DATA_W{1'b0}};
      bus.if_ack     <= 1'b0;
      bus.mem_ack    <= 1'b0;
      if_rdata_hold  <= {DATA_W{1'b0}};
      mem_rdata_hold <= {DATA_W{1'b0}};
`ifdef MEM_ARB_RR_EN
      last_mem       <= 1'b0;
`endif
    end else begin
      bus.ram_ce  <= 1'b0;
      bus.if_ack  <= 1'b0;
      bus.mem_ack <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (resp_read) begin
            if (owner_mem) begin
              mem_rdata_hold <= bus.ram_rdata;
            end else begin
              if_rdata_hold <= bus.ram_rdata;
            end
          end
          if (grant_valid) begin
            state      <= ACCESS;
            bus.ram_ce <= 1'b1;
            owner_mem  <= grant_mem;
`ifdef MEM_ARB_RR_EN
            last_mem   <= grant_mem;
`endif
            if (grant_mem) begin
              bus.ram_addr  <= bus.mem_addr;
              bus.ram_we    <= bus.mem_we;
              bus.ram_wdata <= bus.mem_wdata;
            end else begin
              bus.ram_addr  <= bus.if_addr;
              bus.ram_we    <= {BE_W{1'b0}};
              bus.ram_wdata <= {DATA_W{1'b0}};
            end
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (owner_mem) begin
            bus.mem_ack <= 1'b1;
          end else begin
            bus.if_ack <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: vector table of single transactions plus
// hand-written contention, dropped-request, back-to-back and reset-abort sequences.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_if_rdata  = 32'h0;
  logic [31:0] exp_mem_rdata = 32'h0;
  logic [31:0] ram_model [0:255];

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model, preloaded on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram_model[i] <= 32'h0;
      ram_model[8'h40] <= 32'hDEADBEEF;
      ram_model[8'hFF] <= 32'hCAFEF00D;
      bus.ram_rdata    <= 32'h0;
    end else if (bus.ram_ce) begin
      if (bus.ram_we == 4'b0000) begin
        bus.ram_rdata <= ram_model[bus.ram_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_we[b]) ram_model[bus.ram_addr[9:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic        is_mem;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rdata();
    check("if_rdata", bus.if_rdata, exp_if_rdata);
    check("mem_rdata", bus.mem_rdata, exp_mem_rdata);
  endtask

  // One isolated transaction: req at T, ram_ce at T+1, ack at T+2.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    if (v.is_mem) begin
      bus.mem_req = 1'b1; bus.mem_addr = v.addr; bus.mem_we = v.we; bus.mem_wdata = v.wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = v.addr;
    end
    #1;
    check1("stall_T", v.is_mem ? bus.mem_stall : bus.if_stall, 1'b1);
    check1("ce_T", bus.ram_ce, 1'b0);
    @(negedge clk);
    check1("ce_T1", bus.ram_ce, 1'b1);
    check("addr_T1", bus.ram_addr, v.addr);
    check("we_T1", {28'h0, bus.ram_we}, v.is_mem ? {28'h0, v.we} : 32'h0);
    check("wdata_T1", bus.ram_wdata, v.is_mem ? v.wdata : 32'h0);
    check1("ack_T1", v.is_mem ? bus.mem_ack : bus.if_ack, 1'b0);
    @(negedge clk);
    if (v.we == 4'b0000) begin
      if (v.is_mem) exp_mem_rdata = v.exp_rdata;
      else          exp_if_rdata  = v.exp_rdata;
    end
    check1("ack_T2", v.is_mem ? bus.mem_ack : bus.if_ack, 1'b1);
    check1("other_ack_T2", v.is_mem ? bus.if_ack : bus.mem_ack, 1'b0);
    check1("ce_T2", bus.ram_ce, 1'b0);
    check1("stall_T2", v.is_mem ? bus.mem_stall : bus.if_stall, 1'b0);
    check_rdata();
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    @(negedge clk);
    check1("if_ack_T3", bus.if_ack, 1'b0);
    check1("mem_ack_T3", bus.mem_ack, 1'b0);
    check_rdata();
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0100, 4'b0000, 32'h0,         32'hDEADBEEF};
    vecs[1] = '{1'b1, 32'h0000_0204, 4'b0100, 32'h5A5A5A5A,  32'h0};
    vecs[2] = '{1'b1, 32'h0000_0204, 4'b0000, 32'h0,         32'h005A0000};
    vecs[3] = '{1'b1, 32'h0000_0204, 4'b1111, 32'h12345678,  32'h0};
    vecs[4] = '{1'b1, 32'h0000_0204, 4'b0000, 32'h0,         32'h12345678};
    vecs[5] = '{1'b0, 32'h0000_0204, 4'b0000, 32'h0,         32'h12345678};
    vecs[6] = '{1'b1, 32'h0000_0300, 4'b0011, 32'hAABBCCDD,  32'h0};
    vecs[7] = '{1'b0, 32'h0000_0300, 4'b0000, 32'h0,         32'h0000CCDD};
    vecs[8] = '{1'b1, 32'hFFFF_FFFC, 4'b0000, 32'h0,         32'hCAFEF00D};
    vecs[9] = '{1'b0, 32'h0000_0003, 4'b0000, 32'h0,         32'h00000000};

    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.mem_req = 1'b0; bus.mem_addr = 32'h0; bus.mem_we = 4'b0; bus.mem_wdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check1("rst_ce", bus.ram_ce, 1'b0);
    check("rst_addr", bus.ram_addr, 32'h0);
    check1("rst_if_ack", bus.if_ack, 1'b0);
    check1("rst_mem_ack", bus.mem_ack, 1'b0);
    check_rdata();
    rst = 1'b0;

    // Simultaneous requests: mem first, IF follows directly from RESP
    @(negedge clk);
    bus.if_req = 1'b1;  bus.if_addr = 32'h0000_0100;
    bus.mem_req = 1'b1; bus.mem_addr = 32'hFFFF_FFFC; bus.mem_we = 4'b0000; bus.mem_wdata = 32'h0;
    #1;
    check1("both_if_stall_T", bus.if_stall, 1'b1);
    check1("both_mem_stall_T", bus.mem_stall, 1'b1);
    @(negedge clk);
    check1("both_ce_T1", bus.ram_ce, 1'b1);
    check("both_addr_T1", bus.ram_addr, 32'hFFFF_FFFC);
    check1("both_if_stall_T1", bus.if_stall, 1'b1);
    @(negedge clk);
    exp_mem_rdata = 32'hCAFEF00D;
    check1("both_mem_ack_T2", bus.mem_ack, 1'b1);
    check1("both_if_ack_T2", bus.if_ack, 1'b0);
    check1("both_if_stall_T2", bus.if_stall, 1'b1);
    check_rdata();
    bus.mem_req = 1'b0;
    @(negedge clk);
    check1("both_ce_T3", bus.ram_ce, 1'b1);
    check("both_addr_T3", bus.ram_addr, 32'h0000_0100);
    check1("both_if_stall_T3", bus.if_stall, 1'b1);
    @(negedge clk);
    exp_if_rdata = 32'hDEADBEEF;
    check1("both_if_ack_T4", bus.if_ack, 1'b1);
    check1("both_if_stall_T4", bus.if_stall, 1'b0);
    check_rdata();
    bus.if_req = 1'b0;
    @(negedge clk);
    check1("both_ce_T5", bus.ram_ce, 1'b0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Request dropped after grant still completes
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0300;
    @(negedge clk);
    bus.if_req = 1'b0;
    check1("drop_ce_T1", bus.ram_ce, 1'b1);
    @(negedge clk);
    exp_if_rdata = 32'h0000CCDD;
    check1("drop_ack_T2", bus.if_ack, 1'b1);
    check_rdata();
    @(negedge clk);
    check1("drop_ack_T3", bus.if_ack, 1'b0);
    check1("drop_ce_T3", bus.ram_ce, 1'b0);

    // Both ports pending continuously: MEM, IF, MEM, IF at 2-cycle spacing
    @(negedge clk);
    bus.if_req = 1'b1;  bus.if_addr = 32'h0000_0204;
    bus.mem_req = 1'b1; bus.mem_addr = 32'h0000_0100; bus.mem_we = 4'b0000;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check1("b2b_ce", bus.ram_ce, (k % 2 == 1) && (k < 9));
      check1("b2b_mem_ack", bus.mem_ack, (k == 2) || (k == 6));
      check1("b2b_if_ack", bus.if_ack, (k == 4) || (k == 8));
      if (k == 1 || k == 5) check("b2b_addr_mem", bus.ram_addr, 32'h0000_0100);
      if (k == 3 || k == 7) check("b2b_addr_if", bus.ram_addr, 32'h0000_0204);
      if (k == 2) exp_mem_rdata = 32'hDEADBEEF;
      if (k == 4) exp_if_rdata  = 32'h12345678;
      check_rdata();
      if (k == 6) bus.mem_req = 1'b0;
      if (k == 8) bus.if_req = 1'b0;
    end

    // Reset during ACCESS aborts the read
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
    @(negedge clk);
    check1("abort_ce_T1", bus.ram_ce, 1'b1);
    rst = 1'b1; bus.if_req = 1'b0;
    @(negedge clk);
    exp_if_rdata = 32'h0; exp_mem_rdata = 32'h0;
    check1("abort_ce", bus.ram_ce, 1'b0);
    check("abort_addr", bus.ram_addr, 32'h0);
    check("abort_we", {28'h0, bus.ram_we}, 32'h0);
    check("abort_wdata", bus.ram_wdata, 32'h0);
    check1("abort_if_ack", bus.if_ack, 1'b0);
    check1("abort_mem_ack", bus.mem_ack, 1'b0);
    check_rdata();
    @(negedge clk);
    check1("abort_if_ack_2", bus.if_ack, 1'b0);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check1("abort_no_ack", bus.if_ack, 1'b0);
      check1("abort_no_ce", bus.ram_ce, 1'b0);
    end
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
